// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and sub-word helpers for the pipelined memory stage.
// Byte-enable, store-lane and load-extension helpers assume four 8-bit lanes.
package mem_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  // Unsupported funct3 encodings count as misaligned so they never touch memory.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_B, F3_BU: is_misaligned = 1'b0;
      F3_H, F3_HU: is_misaligned = a[0];
      F3_W:        is_misaligned = (a != 2'b00);
      default:     is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_B, F3_BU: byte_en = 4'b0001 << a;
      F3_H, F3_HU: byte_en = a[1] ? 4'b1100 : 4'b0011;
      F3_W:        byte_en = 4'b1111;
      default:     byte_en = 4'b0000;
    endcase
  endfunction

  // Replicate store data so every enabled lane sees the right bytes.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      F3_B, F3_BU: store_lanes = {4{wd[7:0]}};
      F3_H, F3_HU: store_lanes = {2{wd[15:0]}};
      default:     store_lanes = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    load_ext = {{24{b[7]}}, b};
      F3_BU:   load_ext = {24'h000000, b};
      F3_H:    load_ext = {{16{h[15]}}, h};
      F3_HU:   load_ext = {16'h0000, h};
      default: load_ext = word;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_be.sv
// Byte-lane-enable data memory: synchronous per-lane write, asynchronous word read.
// Contents are deliberately not reset.
module data_mem_be #(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [3:0]           be,
  input  logic [ADDR_BITS-3:0] waddr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  localparam int DEPTH = 2 ** (ADDR_BITS - 2);

  logic [31:0] mem_r [DEPTH];

  // Lane-masked write port
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_r[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[waddr];

endmodule

// File: rtl/mem_stage_pipe.sv
// Pipelined memory stage: sub-word loads/stores with configurable latency,
// writeback selection and the MEM/WB register, with a valid/ready upstream handshake.
module mem_stage_pipe
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_BITS   = 12,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [DATA_WIDTH-1:0] PCPlus4,
  input  logic [1:0]            ResultSrc,
  input  logic                  MemWrite,
  input  logic [2:0]            funct3,
  input  logic [4:0]            RdM,
  input  logic                  RegWriteM,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] Result,
  output logic [4:0]            RdW,
  output logic                  RegWriteW,
  output logic                  Stall,
  output logic                  MisalignErr
);

  localparam int  CW      = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int  LAST    = (MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0;
  localparam bit  HAS_LAT = (MEM_LATENCY > 0);

  state_t                state_r, state_nx_s;
  logic [CW-1:0]         cnt_r;
  logic                  complete_s, capture_s, mis_s, we_s;

  logic [DATA_WIDTH-1:0] addr_r, wd_r, pc_r;
  logic [1:0]            rsrc_r;
  logic                  mw_r, rw_r;
  logic [2:0]            f3_r;
  logic [4:0]            rd_r;

  logic [DATA_WIDTH-1:0] cur_addr_s, cur_wd_s, cur_pc_s, res_s, rdata_s;
  logic [1:0]            cur_rsrc_s;
  logic                  cur_mw_s, cur_rw_s, cur_memop_s;
  logic [2:0]            cur_f3_s;
  logic [4:0]            cur_rd_s;

  logic                  out_valid_r, rw_out_r, mis_out_r;
  logic [DATA_WIDTH-1:0] result_r;
  logic [4:0]            rd_out_r;

  // In ACCESS the captured op drives the datapath; otherwise the live inputs do.
  always_comb begin
    if (state_r == ACCESS) begin
      cur_addr_s = addr_r;    cur_wd_s = wd_r;      cur_pc_s = pc_r;
      cur_rsrc_s = rsrc_r;    cur_mw_s = mw_r;      cur_f3_s = f3_r;
      cur_rd_s   = rd_r;      cur_rw_s = rw_r;
    end else begin
      cur_addr_s = ALUResult; cur_wd_s = WriteData; cur_pc_s = PCPlus4;
      cur_rsrc_s = ResultSrc; cur_mw_s = MemWrite;  cur_f3_s = funct3;
      cur_rd_s   = RdM;       cur_rw_s = RegWriteM;
    end
    cur_memop_s = (cur_rsrc_s == RES_MEM) | cur_mw_s;
    mis_s       = cur_memop_s & is_misaligned(cur_f3_s, cur_addr_s[1:0]);
  end

  // Next-state and completion decode
  always_comb begin
    state_nx_s = state_r;
    complete_s = 1'b0;
    capture_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          if (cur_memop_s && !mis_s && HAS_LAT) begin
            state_nx_s = ACCESS;
            capture_s  = 1'b1;
          end else begin
            complete_s = 1'b1;
          end
        end else begin
          complete_s = 1'b0;
        end
      end
      ACCESS: begin
        if (cnt_r == CW'(LAST)) begin
          complete_s = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = ACCESS;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Writeback selection; a faulting op always writes back zero.
  always_comb begin
    res_s = cur_addr_s;
    if (mis_s) begin
      res_s = '0;
    end else begin
      case (cur_rsrc_s)
        RES_MEM: res_s = load_ext(cur_f3_s, cur_addr_s[1:0], rdata_s);
        RES_PC4: res_s = cur_pc_s;
        default: res_s = cur_addr_s;
      endcase
    end
  end

  // Gating with rst_n discards a store whose completion coincides with reset.
  assign we_s = complete_s & cur_mw_s & ~mis_s & rst_n;

  data_mem_be #(.ADDR_BITS(ADDR_BITS)) u_mem (
    .clk   (clk),
    .we    (we_s),
    .be    (byte_en(cur_f3_s, cur_addr_s[1:0])),
    .waddr (cur_addr_s[ADDR_BITS-1:2]),
    .wdata (store_lanes(cur_f3_s, cur_wd_s)),
    .rdata (rdata_s)
  );

  // FSM state, latency counter and captured op fields
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      addr_r  <= '0; wd_r <= '0; pc_r <= '0; rsrc_r <= 2'b00;
      mw_r    <= 1'b0; f3_r <= 3'b000; rd_r <= 5'd0; rw_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (capture_s) begin
        cnt_r  <= '0;
        addr_r <= ALUResult; wd_r <= WriteData; pc_r <= PCPlus4; rsrc_r <= ResultSrc;
        mw_r   <= MemWrite;  f3_r <= funct3;    rd_r <= RdM;     rw_r   <= RegWriteM;
      end else if (state_r == ACCESS) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= '0;
      end
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      result_r    <= '0;
      rd_out_r    <= 5'd0;
      rw_out_r    <= 1'b0;
      mis_out_r   <= 1'b0;
    end else begin
      out_valid_r <= complete_s;
      mis_out_r   <= complete_s & mis_s;
      if (complete_s) begin
        result_r <= res_s;
        rd_out_r <= cur_rd_s;
        rw_out_r <= cur_rw_s & ~mis_s;
      end
    end
  end

  assign in_ready    = (state_r == IDLE);
  assign Stall       = in_valid & ~in_ready;
  assign out_valid   = out_valid_r;
  assign Result      = result_r;
  assign RdW         = rd_out_r;
  assign RegWriteW   = rw_out_r;
  assign MisalignErr = mis_out_r;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Self-checking bench for mem_stage_pipe (MEM_LATENCY = 2): table-driven ops
// plus hand-written reset, back-to-back and reset-abort sequences.
module tb_mem_stage_pipe;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, MemWrite, RegWriteM;
  logic [31:0] ALUResult, WriteData, PCPlus4, Result;
  logic [1:0]  ResultSrc;
  logic [2:0]  funct3;
  logic [4:0]  RdM, RdW;
  logic        out_valid, RegWriteW, Stall, MisalignErr;

  int passed = 0;
  int total  = 0;

  mem_stage_pipe #(.DATA_WIDTH(32), .ADDR_BITS(12), .MEM_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUResult(ALUResult), .WriteData(WriteData), .PCPlus4(PCPlus4),
    .ResultSrc(ResultSrc), .MemWrite(MemWrite), .funct3(funct3), .RdM(RdM),
    .RegWriteM(RegWriteM), .out_valid(out_valid), .Result(Result), .RdW(RdW),
    .RegWriteW(RegWriteW), .Stall(Stall), .MisalignErr(MisalignErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  rsrc;
    logic [2:0]  f3;
    logic [31:0] addr, wd, pc;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] exp_res;
    logic        exp_rw, exp_mis;
    int          exp_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic wr, logic [1:0] rs, logic [2:0] f3,
                              logic [31:0] a, logic [31:0] wd, logic [4:0] rd, logic rw,
                              logic [31:0] er, logic erw, logic emis, int est);
    vec_t v;
    v.name = n; v.wr = wr; v.rsrc = rs; v.f3 = f3; v.addr = a; v.wd = wd;
    v.pc = 32'h0000_0400; v.rd = rd; v.rw = rw; v.exp_res = er;
    v.exp_rw = erw; v.exp_mis = emis; v.exp_stall = est;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    ALUResult = v.addr; WriteData = v.wd; PCPlus4 = v.pc; ResultSrc = v.rsrc;
    MemWrite = v.wr; funct3 = v.f3; RdM = v.rd; RegWriteM = v.rw;
  endtask

  // Present op, hold it through the stall, then check the MEM/WB outputs.
  task automatic issue(input vec_t v);
    int stalls;
    int cyc;
    drive(v);
    in_valid = 1'b1;
    chk({v.name, ".ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    stalls = 0;
    cyc = 0;
    while (!out_valid && cyc < 16) begin
      stalls += int'(Stall);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk({v.name, ".valid"}, 32'(out_valid), 32'd1);
    chk({v.name, ".result"}, Result, v.exp_res);
    chk({v.name, ".regwrite"}, 32'(RegWriteW), 32'(v.exp_rw));
    chk({v.name, ".rd"}, 32'(RdW), 32'(v.rd));
    chk({v.name, ".misalign"}, 32'(MisalignErr), 32'(v.exp_mis));
    chk({v.name, ".stalls"}, 32'(stalls), 32'(v.exp_stall));
  endtask

  initial begin
    vec_t v;
    //        name        wr    rsrc     f3     addr          wdata         rd     rw    exp_res       erw   emis  stall
    vecs.push_back(mk("alu",   1'b0, RES_ALU, F3_W,  32'h0000_1234, 32'h0,        5'd5,  1'b1, 32'h0000_1234, 1'b1, 1'b0, 0));
    vecs.push_back(mk("pc4",   1'b0, RES_PC4, F3_W,  32'h0000_0055, 32'h0,        5'd1,  1'b1, 32'h0000_0400, 1'b1, 1'b0, 0));
    vecs.push_back(mk("sw10",  1'b1, RES_ALU, F3_W,  32'h0000_0010, 32'h80FF7F01, 5'd0,  1'b0, 32'h0000_0010, 1'b0, 1'b0, 2));
    vecs.push_back(mk("lb10",  1'b0, RES_MEM, F3_B,  32'h0000_0010, 32'h0,        5'd6,  1'b1, 32'h0000_0001, 1'b1, 1'b0, 2));
    vecs.push_back(mk("lb11",  1'b0, RES_MEM, F3_B,  32'h0000_0011, 32'h0,        5'd6,  1'b1, 32'h0000_007F, 1'b1, 1'b0, 2));
    vecs.push_back(mk("lb12",  1'b0, RES_MEM, F3_B,  32'h0000_0012, 32'h0,        5'd6,  1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 2));
    vecs.push_back(mk("lbu12", 1'b0, RES_MEM, F3_BU, 32'h0000_0012, 32'h0,        5'd6,  1'b1, 32'h0000_00FF, 1'b1, 1'b0, 2));
    vecs.push_back(mk("lh12",  1'b0, RES_MEM, F3_H,  32'h0000_0012, 32'h0,        5'd8,  1'b1, 32'hFFFF_80FF, 1'b1, 1'b0, 2));
    vecs.push_back(mk("sw20",  1'b1, RES_ALU, F3_W,  32'h0000_0020, 32'h0,        5'd0,  1'b0, 32'h0000_0020, 1'b0, 1'b0, 2));
    vecs.push_back(mk("sh22",  1'b1, RES_ALU, F3_H,  32'h0000_0022, 32'h1234BEEF, 5'd0,  1'b0, 32'h0000_0022, 1'b0, 1'b0, 2));
    vecs.push_back(mk("lh22",  1'b0, RES_MEM, F3_H,  32'h0000_0022, 32'h0,        5'd9,  1'b1, 32'hFFFF_BEEF, 1'b1, 1'b0, 2));
    vecs.push_back(mk("lhu22", 1'b0, RES_MEM, F3_HU, 32'h0000_0022, 32'h0,        5'd9,  1'b1, 32'h0000_BEEF, 1'b1, 1'b0, 2));
    vecs.push_back(mk("lw20",  1'b0, RES_MEM, F3_W,  32'h0000_0020, 32'h0,        5'd9,  1'b1, 32'hBEEF_0000, 1'b1, 1'b0, 2));
    vecs.push_back(mk("sb21",  1'b1, RES_ALU, F3_B,  32'h0000_0021, 32'h0000_77AB, 5'd0, 1'b0, 32'h0000_0021, 1'b0, 1'b0, 2));
    vecs.push_back(mk("lw20b", 1'b0, RES_MEM, F3_W,  32'h0000_0020, 32'h0,        5'd9,  1'b1, 32'hBEEF_AB00, 1'b1, 1'b0, 2));
    vecs.push_back(mk("lw13",  1'b0, RES_MEM, F3_W,  32'h0000_0013, 32'h0,        5'd7,  1'b1, 32'h0000_0000, 1'b0, 1'b1, 0));
    vecs.push_back(mk("lw10",  1'b0, RES_MEM, F3_W,  32'h0000_0010, 32'h0,        5'd7,  1'b1, 32'h80FF_7F01, 1'b1, 1'b0, 2));
    vecs.push_back(mk("sh11",  1'b1, RES_ALU, F3_H,  32'h0000_0011, 32'h0000_DEAD, 5'd0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 0));
    vecs.push_back(mk("f3bad", 1'b0, RES_MEM, 3'b011, 32'h0000_0010, 32'h0,       5'd4,  1'b1, 32'h0000_0000, 1'b0, 1'b1, 0));
    vecs.push_back(mk("lwwrap",1'b0, RES_MEM, F3_W,  32'h0000_1010, 32'h0,        5'd7,  1'b1, 32'h80FF_7F01, 1'b1, 1'b0, 2));
    vecs.push_back(mk("sw30",  1'b1, RES_ALU, F3_W,  32'h0000_0030, 32'h12345678, 5'd0,  1'b0, 32'h0000_0030, 1'b0, 1'b0, 2));

    // Reset held with a valid op presented
    rst_n = 1'b0;
    drive(mk("rst", 1'b0, RES_ALU, F3_W, 32'hDEAD, 32'h0, 5'd3, 1'b1, 32'h0, 1'b0, 1'b0, 0));
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.result", Result, 32'd0);
    chk("rst.regwrite", 32'(RegWriteW), 32'd0);
    chk("rst.misalign", 32'(MisalignErr), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.ready", 32'(in_ready), 32'd1);
    chk("rst.idlevalid", 32'(out_valid), 32'd0);

    // Table-driven ops
    foreach (vecs[i]) issue(vecs[i]);

    // Three back-to-back ALU ops
    v = mk("b2b", 1'b0, RES_ALU, F3_W, 32'h11, 32'h0, 5'd2, 1'b1, 32'h0, 1'b0, 1'b0, 0);
    drive(v);
    in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk("b2b.valid", 32'(out_valid), 32'd1);
      chk("b2b.result", Result, 32'h11 * k);
      chk("b2b.stall", 32'(Stall), 32'd0);
      ALUResult = 32'h11 * (k + 1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b.pulse", 32'(out_valid), 32'd0);

    // Store accepted, then reset before it commits
    drive(mk("abort", 1'b1, RES_ALU, F3_W, 32'h30, 32'hAAAA5555, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 0));
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort.ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk("abort.novalid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    issue(mk("abort.lw30", 1'b0, RES_MEM, F3_W, 32'h30, 32'h0, 5'd10, 1'b1,
             32'h1234_5678, 1'b1, 1'b0, 2));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_stage_pipe.md
Name: mem_stage_pipe

Overview:
- Parametrised successor to the single-cycle memory stage. It holds a byte-addressable data memory with configurable access latency.
- Supports RV32I sub-word loads and stores (byte/half/word, signed/unsigned) and flags misaligned accesses.
- Selects the writeback value from ALU result, load data or PC+4, then registers it into the MEM/WB pipeline register.
- Sits between the execute stage and writeback. Stalls upstream through a valid/ready handshake while a memory access is in flight.

Parameters:
- DATA_WIDTH, 32, datapath width; fixed at 32 for this generation (sub-word logic assumes 4 byte lanes).
- ADDR_BITS, 12, byte-address bits used; memory depth is 2^ADDR_BITS bytes.
- MEM_LATENCY, 2, extra cycles a load or store occupies the stage; 0 means memory ops complete like ALU ops.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- ALUResult  in  DATA_WIDTH  address or ALU result.
- WriteData  in  DATA_WIDTH  store data, right-justified.
- PCPlus4  in  DATA_WIDTH  link value.
- ResultSrc  in  2  00 = ALU, 01 = load, 10 = PC+4, 11 = reserved (treated as ALU).
- MemWrite  in  1  store.
- funct3  in  3  000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
- RdM  in  5  destination register.
- RegWriteM  in  1  register write enable.
- out_valid  out  1  MEM/WB register holds a completed instruction (one-cycle pulse per instruction).
- Result  out  DATA_WIDTH  writeback value.
- RdW  out  5  registered destination.
- RegWriteW  out  1  registered write enable (0 on misalign).
- Stall  out  1  in_valid & ~in_ready.
- MisalignErr  out  1  one-cycle pulse coincident with out_valid of a faulting op.

Behaviour:
- Reset (rst_n = 0 at an edge):
  - State goes to IDLE; counter clears.
  - out_valid, Result, RdW, RegWriteW and MisalignErr clear to 0; in_ready reads 1 after reset.
  - Memory array is not cleared.
  - Reset during ACCESS aborts the op: a store not yet committed is discarded and no out_valid is produced.
- Memory op definition: ResultSrc == 01 or MemWrite == 1.
- Acceptance: happens at an edge E0 where in_valid & in_ready.
- States: IDLE, ACCESS. in_ready = (state == IDLE).
- Non-memory op accepted at E0:
  - MEM/WB loads at E0, so out_valid = 1 in the following cycle.
  - Result = ALUResult, or PCPlus4 when ResultSrc == 10. Back-to-back issue is allowed every cycle.
- Memory op, aligned, MEM_LATENCY > 0:
  - IDLE -> ACCESS at E0; the op's fields are captured.
  - The counter counts MEM_LATENCY edges. At edge E0 + MEM_LATENCY: the store commits its byte lanes, the load samples the array, MEM/WB loads, and state returns to IDLE.
  - out_valid and in_ready are therefore both 1 in the same cycle, so the next op can be accepted at that cycle's edge.
- MEM_LATENCY == 0: memory ops complete at E0, exactly like non-memory ops; the ACCESS state is never entered.
- Alignment:
  - H/HU need addr[0] == 0; W needs addr[1:0] == 00.
  - Misaligned op: no store and no state change beyond IDLE. MEM/WB loads at E0 with Result = 0, RegWriteW = 0, MisalignErr = 1.
  - funct3 values 011/110/111 are treated as misaligned.
- Stores:
  - SB writes lane addr[1:0] with WriteData[7:0].
  - SH writes lanes {addr[1], 0} and {addr[1], 1} with WriteData[15:0], little-endian.
  - SW writes all 4 lanes.
- Loads: the word at addr[ADDR_BITS-1:2] is read; the byte/half is selected by addr[1:0], then sign-extended (B/H) or zero-extended (BU/HU).
- Address bits above ADDR_BITS are ignored (wrap modulo depth).
- Read-after-write: a load following a store to the same address sees the new data, because the store commits before the load is accepted.
- Input fields are ignored while in_ready = 0. Upstream must hold them while Stall = 1.

Decomposition:
- mem_pkg holds:
  - ResultSrc encodings (RES_ALU, RES_MEM, RES_PC4).
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - state_t enum {IDLE, ACCESS}.
  - Pure functions for byte-enable generation and load extension.
- One sub-module: data_mem_be, a byte-lane-enable synchronous-write memory with 4 x 8-bit lanes and asynchronous word read, parametrised by ADDR_BITS.

Test Plan:
- Reset with in_valid = 1 -> out_valid = 0, Result = 0, RegWriteW = 0, in_ready = 1 after release.
- ALU op ALUResult = 0x1234, RdM = 5, RegWriteM = 1 -> next cycle out_valid = 1, Result = 0x1234, RdW = 5; three consecutive ALU ops produce three consecutive out_valid pulses with no Stall.
- SW 0x80FF7F01 @0x10, then LB @0x10, @0x11, @0x12 and LBU @0x12 (MEM_LATENCY = 2) -> Results 0x00000001, 0x0000007F, 0xFFFFFFFF, 0x000000FF. Each load has out_valid 2 edges after acceptance and Stall high for 2 cycles.
- SH 0xBEEF @0x22, then LH @0x22 -> 0xFFFFBEEF; LHU -> 0x0000BEEF; LW @0x20 -> 0xBEEF0000 when the word was previously 0.
- LW @0x13 -> next cycle MisalignErr = 1, RegWriteW = 0, Result = 0; a following LW @0x10 returns the unchanged word. SH @0x11 leaves memory unchanged.
- SW 0xAAAA5555 @0x30 accepted, rst_n = 0 one cycle later -> no out_valid; after reset, LW @0x30 returns the prior contents.
